// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer and the accumulator CPU.
// Holds the playback state encodings and the instruction word geometry,
// so both blocks take their word width from one place.
package instr_seq_pkg;

    // Instruction word width; the CPU INSTRUCTION input uses the same value.
    localparam int unsigned INSTR_W   = 5;
    // Number of words the sequencer buffer can hold.
    localparam int unsigned SEQ_DEPTH = 8;

    // Playback FSM encodings.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/instr_mem.sv
// Small register-file buffer for the instruction sequencer.
// Ports:
//   clk_i    - clock, write on rising edge
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - combinational read data
// Storage has no reset; contents are undefined until written.
module instr_mem
    import instr_seq_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W,
    parameter int unsigned DEPTH  = SEQ_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: captures a short program over a parallel load port
// and replays it to the accumulator CPU one word per clock with a write_en
// strobe.
// Ports:
//   CLK         - clock
//   RESET       - synchronous active-high reset
//   CLEAR       - synchronous buffer clear (INSTRUCTION holds)
//   LOAD_DATA   - word to append
//   LOAD_VALID  - append LOAD_DATA this cycle
//   RUN         - start or restart playback
//   INSTRUCTION - word presented to the CPU (registered)
//   write_en    - INSTRUCTION valid this cycle (registered)
//   BUSY        - playback in progress
//   DONE        - playback finished
//   MEM_FULL    - buffer holds DEPTH words
//   COUNT       - number of stored words
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W,
    parameter int unsigned DEPTH  = SEQ_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLEAR,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              LOAD_VALID,
    input  logic              RUN,
    output logic [DATA_W-1:0] INSTRUCTION,
    output logic              write_en,
    output logic              BUSY,
    output logic              DONE,
    output logic              MEM_FULL,
    output logic [ADDR_W:0]   COUNT
);

    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CntOne    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              we_q, we_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_rdata;

    instr_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (LOAD_DATA),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        instr_d   = instr_q;
        we_d      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;

        if (CLEAR) begin
            state_d  = S_IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // RUN takes precedence over a same-cycle load.
                    if (RUN && (count_q != '0)) begin
                        state_d  = S_PLAY;
                        rd_ptr_d = '0;
                    end else if (LOAD_VALID && (count_q != FullCount)) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                        count_d  = count_q + CntOne;
                    end
                end
                S_PLAY: begin
                    instr_d  = mem_rdata;
                    we_d     = 1'b1;
                    rd_ptr_d = rd_ptr_q + PtrOne;
                    if ({1'b0, rd_ptr_q} == (count_q - CntOne)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (RUN) begin
                        state_d  = S_PLAY;
                        rd_ptr_d = '0;
                    end else if (LOAD_VALID) begin
                        // A load after playback starts a fresh program at slot 0.
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        count_d   = CntOne;
                        wr_ptr_d  = PtrOne;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Buffer writes are suppressed on a reset edge.
        if (RESET) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            instr_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            instr_q  <= instr_d;
            we_q     <= we_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign write_en    = we_q;
    assign BUSY        = (state_q == S_PLAY);
    assign DONE        = (state_q == S_DONE);
    assign MEM_FULL    = (count_q == FullCount);
    assign COUNT       = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a table of per-cycle vectors for
// load/playback/replay behaviour, plus hand-written sequences for overflow
// and mid-playback RESET/CLEAR.
module tb_instr_sequencer;

    logic       CLK;
    logic       RESET;
    logic       CLEAR;
    logic [4:0] LOAD_DATA;
    logic       LOAD_VALID;
    logic       RUN;
    logic [4:0] INSTRUCTION;
    logic       write_en;
    logic       BUSY;
    logic       DONE;
    logic       MEM_FULL;
    logic [3:0] COUNT;

    int checks = 0;
    int errors = 0;

    instr_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CLEAR       (CLEAR),
        .LOAD_DATA   (LOAD_DATA),
        .LOAD_VALID  (LOAD_VALID),
        .RUN         (RUN),
        .INSTRUCTION (INSTRUCTION),
        .write_en    (write_en),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .MEM_FULL    (MEM_FULL),
        .COUNT       (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       clear;
        logic       lv;
        logic [4:0] ld;
        logic       run;
        logic [4:0] ei;
        logic       ew;
        logic       eb;
        logic       ed;
        logic       ef;
        logic [3:0] ec;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic clear, input logic lv, input logic [4:0] ld,
                                input logic run, input logic [4:0] ei, input logic ew,
                                input logic eb, input logic ed, input logic ef,
                                input logic [3:0] ec);
        vec_t v;
        v.clear = clear; v.lv = lv; v.ld = ld; v.run = run;
        v.ei = ei; v.ew = ew; v.eb = eb; v.ed = ed; v.ef = ef; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        CLEAR = 1'b0; LOAD_VALID = 1'b0; LOAD_DATA = 5'h00; RUN = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
    endtask

    task automatic load(input logic [4:0] d);
        LOAD_VALID = 1'b1; LOAD_DATA = d;
        cyc();
        idle_inputs();
    endtask

    task automatic check_all(input string tag, input logic [4:0] ei, input logic ew,
                             input logic eb, input logic ed, input logic ef,
                             input logic [3:0] ec);
        chk({tag, " instr"}, 32'(INSTRUCTION), 32'(ei));
        chk({tag, " we"},    32'(write_en),    32'(ew));
        chk({tag, " busy"},  32'(BUSY),        32'(eb));
        chk({tag, " done"},  32'(DONE),        32'(ed));
        chk({tag, " full"},  32'(MEM_FULL),    32'(ef));
        chk({tag, " count"}, 32'(COUNT),       32'(ec));
    endtask

    initial begin
        //               clr lv  ld    run  instr  we bsy dn ful cnt
        tbl[0]  = mk(0, 1, 5'h03, 0, 5'h00, 0, 0, 0, 0, 4'd1);
        tbl[1]  = mk(0, 1, 5'h0A, 0, 5'h00, 0, 0, 0, 0, 4'd2);
        tbl[2]  = mk(0, 1, 5'h11, 0, 5'h00, 0, 0, 0, 0, 4'd3);
        tbl[3]  = mk(0, 0, 5'h00, 1, 5'h00, 0, 1, 0, 0, 4'd3);
        tbl[4]  = mk(0, 0, 5'h00, 0, 5'h03, 1, 1, 0, 0, 4'd3);
        tbl[5]  = mk(0, 0, 5'h00, 0, 5'h0A, 1, 1, 0, 0, 4'd3);
        tbl[6]  = mk(0, 0, 5'h00, 0, 5'h11, 1, 0, 1, 0, 4'd3);
        tbl[7]  = mk(0, 0, 5'h00, 0, 5'h11, 0, 0, 1, 0, 4'd3);
        // Replay from DONE.
        tbl[8]  = mk(0, 0, 5'h00, 1, 5'h11, 0, 1, 0, 0, 4'd3);
        tbl[9]  = mk(0, 0, 5'h00, 0, 5'h03, 1, 1, 0, 0, 4'd3);
        tbl[10] = mk(0, 0, 5'h00, 0, 5'h0A, 1, 1, 0, 0, 4'd3);
        tbl[11] = mk(0, 0, 5'h00, 0, 5'h11, 1, 0, 1, 0, 4'd3);
        tbl[12] = mk(0, 0, 5'h00, 0, 5'h11, 0, 0, 1, 0, 4'd3);
        // Load in DONE starts a new one-word program; RUN beats LOAD_VALID.
        tbl[13] = mk(0, 1, 5'h1F, 0, 5'h11, 0, 0, 0, 0, 4'd1);
        tbl[14] = mk(0, 1, 5'h05, 1, 5'h11, 0, 1, 0, 0, 4'd1);
        tbl[15] = mk(0, 0, 5'h00, 0, 5'h1F, 1, 0, 1, 0, 4'd1);
        tbl[16] = mk(0, 0, 5'h00, 0, 5'h1F, 0, 0, 1, 0, 4'd1);
        // CLEAR from DONE, then RUN with an empty buffer is ignored.
        tbl[17] = mk(1, 0, 5'h00, 0, 5'h1F, 0, 0, 0, 0, 4'd0);
        tbl[18] = mk(0, 0, 5'h00, 1, 5'h1F, 0, 0, 0, 0, 4'd0);
        tbl[19] = mk(0, 1, 5'h04, 0, 5'h1F, 0, 0, 0, 0, 4'd1);
        tbl[20] = mk(0, 1, 5'h06, 0, 5'h1F, 0, 0, 0, 0, 4'd2);
        // RUN with LOAD_VALID in IDLE: load dropped, two words played.
        tbl[21] = mk(0, 1, 5'h09, 1, 5'h1F, 0, 1, 0, 0, 4'd2);
        tbl[22] = mk(0, 0, 5'h00, 0, 5'h04, 1, 1, 0, 0, 4'd2);
        tbl[23] = mk(0, 0, 5'h00, 0, 5'h06, 1, 0, 1, 0, 4'd2);
        tbl[24] = mk(0, 0, 5'h00, 0, 5'h06, 0, 0, 1, 0, 4'd2);

        RESET = 1'b0;
        idle_inputs();
        cyc();
        do_reset();
        check_all("reset", 5'h00, 0, 0, 0, 0, 4'd0);

        for (int i = 0; i < NV; i++) begin
            CLEAR = tbl[i].clear; LOAD_VALID = tbl[i].lv;
            LOAD_DATA = tbl[i].ld; RUN = tbl[i].run;
            cyc();
            idle_inputs();
            check_all($sformatf("row%0d", i), tbl[i].ei, tbl[i].ew, tbl[i].eb,
                      tbl[i].ed, tbl[i].ef, tbl[i].ec);
        end

        // Overflow: ten loads, only eight kept.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            load(5'(i));
            chk($sformatf("ovf count%0d", i), 32'(COUNT), (i < 8) ? 32'(i + 1) : 32'd8);
            chk($sformatf("ovf full%0d", i), 32'(MEM_FULL), (i >= 7) ? 32'd1 : 32'd0);
        end
        RUN = 1'b1;
        cyc();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("ovf play we%0d", i), 32'(write_en), 32'd1);
            chk($sformatf("ovf play word%0d", i), 32'(INSTRUCTION), 32'(i));
        end
        cyc();
        chk("ovf end we", 32'(write_en), 32'd0);
        chk("ovf end done", 32'(DONE), 32'd1);

        // Mid-play RESET after the second of four words.
        do_reset();
        load(5'h11); load(5'h12); load(5'h13); load(5'h14);
        RUN = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        cyc();
        chk("rst 2nd word", 32'(INSTRUCTION), 32'h12);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        check_all("rst mid", 5'h00, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rst quiet%0d", i), 32'(write_en), 32'd0);
        end

        // Mid-play CLEAR after the second of four words.
        load(5'h01); load(5'h02); load(5'h03); load(5'h04);
        RUN = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        cyc();
        chk("clr 2nd word", 32'(INSTRUCTION), 32'h02);
        CLEAR = 1'b1;
        cyc();
        idle_inputs();
        check_all("clr mid", 5'h02, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("clr quiet%0d", i), 32'(write_en), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
